// File: rtl/peri_arbiter_if.sv
// Requester-side and bridge-side signals of the peripheral arbiter.
// slave is the arbiter's view; master is the requesters' and bridge's view.
interface peri_arbiter_if;
    logic        REQ0, REQ1;
    logic [31:0] ADDR0, ADDR1;
    logic        WRITE0, WRITE1;
    logic [31:0] WDATA0, WDATA1;
    logic [3:0]  WSTRB0, WSTRB1;
    logic        ACK0, ACK1;
    logic [31:0] RDATA0, RDATA1;
    logic        ERR0, ERR1;
    logic        P_START;
    logic [31:0] P_ADDRESS;
    logic        P_WRITE;
    logic [31:0] P_DATA_IN;
    logic [3:0]  P_WSTRB;
    logic [31:0] P_DATA_OUT;
    logic        P_DONE;
    logic        P_CACHE_READY;

    modport slave (
        input  REQ0, REQ1, ADDR0, ADDR1, WRITE0, WRITE1,
               WDATA0, WDATA1, WSTRB0, WSTRB1, P_DATA_OUT, P_DONE,
        output ACK0, ACK1, RDATA0, RDATA1, ERR0, ERR1,
               P_START, P_ADDRESS, P_WRITE, P_DATA_IN, P_WSTRB, P_CACHE_READY
    );

    modport master (
        output REQ0, REQ1, ADDR0, ADDR1, WRITE0, WRITE1,
               WDATA0, WDATA1, WSTRB0, WSTRB1, P_DATA_OUT, P_DONE,
        input  ACK0, ACK1, RDATA0, RDATA1, ERR0, ERR1,
               P_START, P_ADDRESS, P_WRITE, P_DATA_IN, P_WSTRB, P_CACHE_READY
    );
endinterface

// File: rtl/peri_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the START/DONE peripheral bridge.
// Issues one-cycle START, releases sticky DONE, returns data or a timeout error.
module peri_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input logic           CLK,
    input logic           RSTN,
    peri_arbiter_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RELEASE, S_RESP, S_ORPHAN
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last, r_win, r_discard, r_err;
    logic [31:0]      r_resp;
    logic [31:0]      r_addr, r_wdata;
    logic             r_write;
    logic [3:0]       r_wstrb;
    logic             r_ack0, r_ack1, r_err0, r_err1;
    logic [31:0]      r_rdata0, r_rdata1;

    logic             w_any, w_win, w_timeout, w_start, w_cache_ready;
    logic [31:0]      w_rsp_data;
    logic             w_rsp_err;

    assign w_any     = io_bus.REQ0 | io_bus.REQ1;
    // On a tie the port not granted last wins; otherwise whoever asks.
    assign w_win     = (io_bus.REQ0 & io_bus.REQ1) ? ~r_last : io_bus.REQ1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // RESP is entered from WAIT only on a timeout, from RELEASE only with data.
    assign w_rsp_data = (r_state == S_WAIT) ? '0 : r_resp;
    assign w_rsp_err  = (r_state == S_WAIT);

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_cache_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.P_DONE)  w_state_nxt = S_RELEASE;
                else if (w_any)     w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (io_bus.P_DONE)  w_state_nxt = S_RELEASE;
                else if (w_timeout) w_state_nxt = S_RESP;
            end
            S_RELEASE: begin
                w_cache_ready = io_bus.P_DONE;
                if (!io_bus.P_DONE) w_state_nxt = r_discard ? S_IDLE : S_RESP;
            end
            S_RESP:   w_state_nxt = r_err ? S_ORPHAN : S_IDLE;
            S_ORPHAN: if (io_bus.P_DONE) w_state_nxt = S_RELEASE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;
            r_win     <= 1'b0;
            r_discard <= 1'b0;
            r_err     <= 1'b0;
            r_resp    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_wstrb   <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.P_DONE) begin
                        r_discard <= 1'b1;
                    end else if (w_any) begin
                        r_win   <= w_win;
                        r_last  <= w_win;
                        r_addr  <= w_win ? io_bus.ADDR1  : io_bus.ADDR0;
                        r_write <= w_win ? io_bus.WRITE1 : io_bus.WRITE0;
                        r_wdata <= w_win ? io_bus.WDATA1 : io_bus.WDATA0;
                        r_wstrb <= w_win ? io_bus.WSTRB1 : io_bus.WSTRB0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (io_bus.P_DONE) begin
                        r_resp <= io_bus.P_DATA_OUT;
                        r_err  <= 1'b0;
                    end else begin
                        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_err  <= 1'b1;
                            r_resp <= '0;
                        end
                    end
                end
                S_RELEASE: if (!io_bus.P_DONE) r_discard <= 1'b0;
                S_ORPHAN:  if (io_bus.P_DONE)  r_discard <= 1'b1;
                default: ;
            endcase
            // Response lands in the per-port registers on RESP entry and then holds.
            if (w_state_nxt == S_RESP) begin
                if (r_win) begin
                    r_ack1   <= 1'b1;
                    r_rdata1 <= w_rsp_data;
                    r_err1   <= w_rsp_err;
                end else begin
                    r_ack0   <= 1'b1;
                    r_rdata0 <= w_rsp_data;
                    r_err0   <= w_rsp_err;
                end
            end
        end
    end

    assign io_bus.P_START       = w_start;
    assign io_bus.P_CACHE_READY = w_cache_ready;
    assign io_bus.P_ADDRESS     = r_addr;
    assign io_bus.P_WRITE       = r_write;
    assign io_bus.P_DATA_IN     = r_wdata;
    assign io_bus.P_WSTRB       = r_wstrb;
    assign io_bus.ACK0          = r_ack0;
    assign io_bus.ACK1          = r_ack1;
    assign io_bus.RDATA0        = r_rdata0;
    assign io_bus.RDATA1        = r_rdata1;
    assign io_bus.ERR0          = r_err0;
    assign io_bus.ERR1          = r_err1;
endmodule
